// File: rtl/pipe_skid_stage.sv
// Multi-lane pipeline stage register backed by a small circular skid queue.
// Accept and valid outputs come only from registered state, so no path runs from in_* to out_*.
module pipe_skid_stage #(
  parameter int DATA_W = 160,
  parameter int LANES  = 2,
  parameter int DEPTH  = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush_i,
  input  logic [LANES-1:0]              in_valid_i,
  input  logic [LANES*DATA_W-1:0]       in_data_i,
  output logic                          in_allowin_o,
  output logic [LANES-1:0]              out_valid_o,
  output logic [LANES*DATA_W-1:0]       out_data_o,
  input  logic                          out_allowin_i,
  output logic [$clog2(DEPTH+1)-1:0]    occupancy_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [LANES-1:0]        valid_q [DEPTH];
  logic [LANES*DATA_W-1:0] data_q  [DEPTH];
  logic [PTR_W-1:0]        rd_ptr;
  logic [PTR_W-1:0]        wr_ptr;
  logic [CNT_W-1:0]        count;

  logic                    push;
  logic                    pop;
  logic                    not_empty;
  logic [PTR_W-1:0]        rd_ptr_inc;
  logic [PTR_W-1:0]        wr_ptr_inc;
  logic [LANES*DATA_W-1:0] head_data;

  assign not_empty    = (count != '0);
  // A pop never frees a slot for a push in the same cycle: keeps allowin registered.
  assign in_allowin_o = (count < CNT_W'(DEPTH));
  assign push         = (|in_valid_i) & in_allowin_o & ~flush_i;
  assign pop          = not_empty & out_allowin_i & ~flush_i;
  assign occupancy_o  = count;

  assign rd_ptr_inc = (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
  assign wr_ptr_inc = (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) valid_q[i] <= '0;
    end else if (flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) valid_q[i] <= '0;
    end else begin
      if (push) begin
        valid_q[wr_ptr] <= in_valid_i;
        wr_ptr          <= wr_ptr_inc;
      end
      if (pop) rd_ptr <= rd_ptr_inc;
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage is never cleared; stale lanes are hidden by the output mask.
  always_ff @(posedge clk) begin
    if (push && rst_n) data_q[wr_ptr] <= in_data_i;
  end

  assign out_valid_o = not_empty ? valid_q[rd_ptr] : '0;
  assign head_data   = data_q[rd_ptr];

  always_comb begin
    out_data_o = '0;
    for (int k = 0; k < LANES; k++) begin
      if (out_valid_o[k]) out_data_o[k*DATA_W +: DATA_W] = head_data[k*DATA_W +: DATA_W];
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage: a DEPTH=2 instance for most scenarios and a DEPTH=3 one for wrap.
module tb_pipe_skid_stage;

  localparam int DW = 16;
  localparam int LN = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic [LN-1:0] in_valid;
  logic [31:0]   in_data;
  logic          in_allowin;
  logic [LN-1:0] out_valid;
  logic [31:0]   out_data;
  logic          out_allowin;
  logic [1:0]    occupancy;

  logic          flush3;
  logic [LN-1:0] in_valid3;
  logic [31:0]   in_data3;
  logic          in_allowin3;
  logic [LN-1:0] out_valid3;
  logic [31:0]   out_data3;
  logic          out_allowin3;
  logic [1:0]    occupancy3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_skid_stage #(.DATA_W(DW), .LANES(LN), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush),
    .in_valid_i(in_valid), .in_data_i(in_data), .in_allowin_o(in_allowin),
    .out_valid_o(out_valid), .out_data_o(out_data),
    .out_allowin_i(out_allowin), .occupancy_o(occupancy)
  );

  pipe_skid_stage #(.DATA_W(DW), .LANES(LN), .DEPTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush3),
    .in_valid_i(in_valid3), .in_data_i(in_data3), .in_allowin_o(in_allowin3),
    .out_valid_o(out_valid3), .out_data_o(out_data3),
    .out_allowin_i(out_allowin3), .occupancy_o(occupancy3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = '0; in_data = '0; out_allowin = 1'b0;
    flush3 = 1'b0; in_valid3 = '0; in_data3 = '0; out_allowin3 = 1'b0;
    tick();
    tick();
    checks++; if (out_valid !== 2'b00) begin errors++; $display("[TB] FAIL reset_valid got=%b exp=00", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_data got=%h exp=0", out_data); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("[TB] FAIL reset_occ got=%0d exp=0", occupancy); end
    checks++; if (in_allowin !== 1'b1) begin errors++; $display("[TB] FAIL reset_allowin got=%b exp=1", in_allowin); end
    checks++; if (occupancy3 !== 2'd0 || in_allowin3 !== 1'b1) begin errors++; $display("[TB] FAIL reset_d3 occ=%0d allow=%b exp 0/1", occupancy3, in_allowin3); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    in_valid = 2'b11; in_data = {16'hBBBB, 16'hAAAA}; out_allowin = 1'b1;
    tick();
    in_valid = 2'b00; in_data = '0;
    checks++; if (out_valid !== 2'b11) begin errors++; $display("[TB] FAIL basic_valid got=%b exp=11", out_valid); end
    checks++; if (out_data !== 32'hBBBB_AAAA) begin errors++; $display("[TB] FAIL basic_data got=%h exp=bbbbaaaa", out_data); end
    checks++; if (occupancy !== 2'd1) begin errors++; $display("[TB] FAIL basic_occ got=%0d exp=1", occupancy); end
    tick();
    checks++; if (occupancy !== 2'd0 || out_valid !== 2'b00) begin errors++; $display("[TB] FAIL basic_drain occ=%0d valid=%b exp 0/00", occupancy, out_valid); end
  endtask

  task automatic test_backpressure();
    out_allowin = 1'b0;
    in_valid = 2'b11; in_data = {16'h0E01, 16'h0E00};
    tick();
    in_data = {16'h1E01, 16'h1E00};
    tick();
    checks++; if (occupancy !== 2'd2) begin errors++; $display("[TB] FAIL bp_full_occ got=%0d exp=2", occupancy); end
    checks++; if (in_allowin !== 1'b0) begin errors++; $display("[TB] FAIL bp_full_allowin got=%b exp=0", in_allowin); end
    checks++; if (out_data !== 32'h0E01_0E00) begin errors++; $display("[TB] FAIL bp_head_e0 got=%h exp=0e010e00", out_data); end
    in_data = {16'h2E01, 16'h2E00};
    out_allowin = 1'b1;
    tick();
    checks++; if (occupancy !== 2'd1) begin errors++; $display("[TB] FAIL bp_no_bypass_occ got=%0d exp=1", occupancy); end
    checks++; if (out_data !== 32'h1E01_1E00) begin errors++; $display("[TB] FAIL bp_head_e1 got=%h exp=1e011e00", out_data); end
    checks++; if (in_allowin !== 1'b1) begin errors++; $display("[TB] FAIL bp_allowin_after_pop got=%b exp=1", in_allowin); end
    tick();
    in_valid = 2'b00; in_data = '0;
    checks++; if (occupancy !== 2'd1 || out_data !== 32'h2E01_2E00) begin errors++; $display("[TB] FAIL bp_head_e2 occ=%0d data=%h exp 1/2e012e00", occupancy, out_data); end
    tick();
    checks++; if (occupancy !== 2'd0) begin errors++; $display("[TB] FAIL bp_empty got=%0d exp=0", occupancy); end
  endtask

  task automatic test_stream();
    logic [31:0] exp_word;
    out_allowin = 1'b1;
    for (int i = 0; i < 10; i++) begin
      exp_word = {16'h1000 + 16'(i), 16'h2000 + 16'(i)};
      in_valid = 2'b11; in_data = exp_word;
      tick();
      checks++; if (out_data !== exp_word || occupancy !== 2'd1) begin errors++; $display("[TB] FAIL stream_%0d data=%h occ=%0d exp %h/1", i, out_data, occupancy, exp_word); end
    end
    in_valid = 2'b00; in_data = '0;
    tick();
    checks++; if (occupancy !== 2'd0 || out_valid !== 2'b00) begin errors++; $display("[TB] FAIL stream_drain occ=%0d valid=%b exp 0/00", occupancy, out_valid); end
  endtask

  task automatic test_partial();
    out_allowin = 1'b0;
    in_valid = 2'b10; in_data = {16'hBEEF, 16'hDEAD};
    tick();
    in_valid = 2'b00; in_data = '0;
    checks++; if (out_valid !== 2'b10) begin errors++; $display("[TB] FAIL partial_valid got=%b exp=10", out_valid); end
    checks++; if (out_data !== 32'hBEEF_0000) begin errors++; $display("[TB] FAIL partial_mask got=%h exp=beef0000", out_data); end
    out_allowin = 1'b1;
    tick();
    checks++; if (occupancy !== 2'd0) begin errors++; $display("[TB] FAIL partial_drain got=%0d exp=0", occupancy); end
    tick();
    checks++; if (occupancy !== 2'd0) begin errors++; $display("[TB] FAIL idle_no_push got=%0d exp=0", occupancy); end
  endtask

  task automatic test_flush();
    out_allowin = 1'b0;
    in_valid = 2'b11; in_data = {16'hF001, 16'hF000};
    tick();
    in_data = {16'hF101, 16'hF100};
    tick();
    flush = 1'b1; out_allowin = 1'b1; in_data = {16'h9999, 16'h8888};
    tick();
    flush = 1'b0; in_valid = 2'b00; in_data = '0;
    checks++; if (occupancy !== 2'd0) begin errors++; $display("[TB] FAIL flush_occ got=%0d exp=0", occupancy); end
    checks++; if (out_valid !== 2'b00 || out_data !== 32'h0) begin errors++; $display("[TB] FAIL flush_out valid=%b data=%h exp 00/0", out_valid, out_data); end
    checks++; if (in_allowin !== 1'b1) begin errors++; $display("[TB] FAIL flush_allowin got=%b exp=1", in_allowin); end
    out_allowin = 1'b0;
    in_valid = 2'b11; in_data = {16'hF201, 16'hF200};
    tick();
    flush = 1'b1; in_data = {16'h7777, 16'h6666};
    tick();
    flush = 1'b0; in_valid = 2'b00; in_data = '0;
    checks++; if (occupancy !== 2'd0 || out_valid !== 2'b00) begin errors++; $display("[TB] FAIL flush_drop_push occ=%0d valid=%b exp 0/00", occupancy, out_valid); end
    tick();
    checks++; if (occupancy !== 2'd0) begin errors++; $display("[TB] FAIL flush_stays_empty got=%0d exp=0", occupancy); end
  endtask

  task automatic test_reset_midstream();
    out_allowin = 1'b0;
    in_valid = 2'b11; in_data = {16'hA001, 16'hA000};
    tick();
    in_data = {16'hA101, 16'hA100};
    tick();
    rst_n = 1'b0; flush = 1'b1; in_data = {16'h5555, 16'h4444};
    tick();
    rst_n = 1'b1; flush = 1'b0; in_valid = 2'b00; in_data = '0;
    checks++; if (occupancy !== 2'd0 || in_allowin !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_state occ=%0d allow=%b exp 0/1", occupancy, in_allowin); end
    checks++; if (out_valid !== 2'b00 || out_data !== 32'h0) begin errors++; $display("[TB] FAIL rst_mid_out valid=%b data=%h exp 00/0", out_valid, out_data); end
  endtask

  task automatic test_depth3_wrap();
    logic [31:0] exp_word;
    out_allowin3 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid3 = 2'b11; in_data3 = {16'hC000 + 16'(i), 16'hD000 + 16'(i)};
      tick();
    end
    in_valid3 = 2'b00; in_data3 = '0;
    checks++; if (occupancy3 !== 2'd3 || in_allowin3 !== 1'b0) begin errors++; $display("[TB] FAIL d3_full occ=%0d allow=%b exp 3/0", occupancy3, in_allowin3); end
    checks++; if (out_data3 !== 32'hC000_D000) begin errors++; $display("[TB] FAIL d3_head0 got=%h exp=c000d000", out_data3); end
    out_allowin3 = 1'b1;
    tick();
    checks++; if (occupancy3 !== 2'd2 || out_data3 !== 32'hC001_D001) begin errors++; $display("[TB] FAIL d3_pop occ=%0d data=%h exp 2/c001d001", occupancy3, out_data3); end
    for (int k = 0; k < 7; k++) begin
      in_valid3 = 2'b11; in_data3 = {16'hC003 + 16'(k), 16'hD003 + 16'(k)};
      exp_word = {16'hC002 + 16'(k), 16'hD002 + 16'(k)};
      tick();
      checks++; if (out_data3 !== exp_word || occupancy3 !== 2'd2) begin errors++; $display("[TB] FAIL d3_wrap_%0d data=%h occ=%0d exp %h/2", k, out_data3, occupancy3, exp_word); end
    end
    in_valid3 = 2'b00; in_data3 = '0;
    tick();
    checks++; if (occupancy3 !== 2'd1 || out_data3 !== 32'hC009_D009) begin errors++; $display("[TB] FAIL d3_tail occ=%0d data=%h exp 1/c009d009", occupancy3, out_data3); end
    tick();
    checks++; if (occupancy3 !== 2'd0 || out_valid3 !== 2'b00) begin errors++; $display("[TB] FAIL d3_empty occ=%0d valid=%b exp 0/00", occupancy3, out_valid3); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_stream();
    test_partial();
    test_flush();
    test_reset_midstream();
    test_depth3_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
